// File: rtl/bist_misr_analyzer.sv
// BIST output response analyzer: compacts CUT responses into a Galois MISR
// between init and finish strobes, then issues a registered pass/fail verdict.
module bist_misr_analyzer #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] POLY      = 'hB8,
  parameter logic [WIDTH-1:0] SEED      = '0,
  parameter logic [WIDTH-1:0] GOLDEN    = '0,
  parameter int              EXP_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             running,
  input  logic             finish,
  input  logic [WIDTH-1:0] cut_out,
  output logic [WIDTH-1:0] signature,
  output logic [7:0]       cycle_count,
  output logic             sig_valid,
  output logic             pass,
  output logic             fail
);

  typedef enum logic [1:0] {IDLE, COMPACT, CHECK, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sig_nx, misr_step;
  logic [7:0]       cnt_nx;
  logic             valid_nx, pass_nx, fail_nx, match;

  assign misr_step = {signature[WIDTH-2:0], 1'b0}
                   ^ (signature[WIDTH-1] ? POLY : '0)
                   ^ cut_out;
  assign match = (signature == GOLDEN) && (cycle_count == 8'(EXP_CYCLES));

  always_comb begin
    state_nx = state;
    sig_nx   = signature;
    cnt_nx   = cycle_count;
    valid_nx = sig_valid;
    pass_nx  = pass;
    fail_nx  = fail;
    if (init) begin
      // init outranks finish, so a simultaneous pair re-arms without a verdict
      state_nx = COMPACT;
      sig_nx   = SEED;
      cnt_nx   = '0;
      valid_nx = 1'b0;
      pass_nx  = 1'b0;
      fail_nx  = 1'b0;
    end else begin
      case (state)
        COMPACT: begin
          if (finish) begin
            state_nx = CHECK;
          end else if (running) begin
            sig_nx = misr_step;
            if (cycle_count != 8'hFF) cnt_nx = cycle_count + 8'd1;
          end
        end
        CHECK: begin
          state_nx = DONE;
          valid_nx = 1'b1;
          pass_nx  = match;
          fail_nx  = !match;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      signature   <= SEED;
      cycle_count <= '0;
      sig_valid   <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_nx;
      signature   <= sig_nx;
      cycle_count <= cnt_nx;
      sig_valid   <= valid_nx;
      pass        <= pass_nx;
      fail        <= fail_nx;
    end
  end

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Self-checking bench for bist_misr_analyzer: directed vector table, a
// counter saturation sequence, and random strobes against a queue-based model.
module tb_bist_misr_analyzer;

  localparam int         W    = 4;
  localparam logic [3:0] POLY = 4'h3;
  localparam logic [3:0] SEED = 4'h0;
  localparam logic [3:0] GOLD = 4'hB;
  localparam int         EXPC = 3;

  logic       clk = 1'b0;
  logic       reset, init, running, finish;
  logic [3:0] cut_out, signature;
  logic [7:0] cycle_count;
  logic       sig_valid, pass, fail;

  int n_pass = 0;
  int n_tot  = 0;

  bist_misr_analyzer #(
    .WIDTH(W), .POLY(POLY), .SEED(SEED), .GOLDEN(GOLD), .EXP_CYCLES(EXPC)
  ) dut (
    .clk(clk), .reset(reset), .init(init), .running(running), .finish(finish),
    .cut_out(cut_out), .signature(signature), .cycle_count(cycle_count),
    .sig_valid(sig_valid), .pass(pass), .fail(fail)
  );

  always #5 clk = ~clk;

  // Reference model: words compacted since init are kept in a queue and the
  // signature is recomputed from scratch as a polynomial fold over them.
  int         m_mode;   // 0 idle, 1 compacting, 2 evaluating, 3 done
  int         m_words[$];
  logic       m_v, m_p, m_f;

  function automatic int fold_sig();
    int s = int'(SEED);
    foreach (m_words[k]) begin
      s = s * 2;
      if (s >= 16) s = (s - 16) ^ int'(POLY);
      s = s ^ m_words[k];
    end
    return s;
  endfunction

  function automatic int m_cnt();
    return (m_words.size() > 255) ? 255 : m_words.size();
  endfunction

  task automatic model_edge(input logic r, i, ru, f, input logic [3:0] c);
    if (r) begin
      m_mode = 0; m_words.delete(); m_v = 0; m_p = 0; m_f = 0;
    end else if (i) begin
      m_mode = 1; m_words.delete(); m_v = 0; m_p = 0; m_f = 0;
    end else if (m_mode == 1) begin
      if (f) m_mode = 2;
      else if (ru) m_words.push_back(int'(c));
    end else if (m_mode == 2) begin
      m_v = 1;
      m_p = (fold_sig() == int'(GOLD)) && (m_cnt() == EXPC);
      m_f = !m_p;
      m_mode = 3;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input logic r, i, ru, f, input logic [3:0] c);
    reset = r; init = i; running = ru; finish = f; cut_out = c;
    @(posedge clk);
    #1;
    model_edge(r, i, ru, f, c);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".sig"},   int'(signature),   fold_sig());
    chk({tag, ".cnt"},   int'(cycle_count), m_cnt());
    chk({tag, ".valid"}, int'(sig_valid),   int'(m_v));
    chk({tag, ".pass"},  int'(pass),        int'(m_p));
    chk({tag, ".fail"},  int'(fail),        int'(m_f));
  endtask

  typedef struct {
    logic       r, i, ru, f;
    logic [3:0] c;
    logic [3:0] e_sig;
    logic [7:0] e_cnt;
    logic       e_v, e_p, e_f;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, i, ru, f, logic [3:0] c,
                              logic [3:0] es, logic [7:0] ec, logic ev, ep, ef);
    vec_t v;
    v.r = r; v.i = i; v.ru = ru; v.f = f; v.c = c;
    v.e_sig = es; v.e_cnt = ec; v.e_v = ev; v.e_p = ep; v.e_f = ef;
    return v;
  endfunction

  initial begin
    reset = 1; init = 0; running = 0; finish = 0; cut_out = '0;
    m_mode = 0; m_v = 0; m_p = 0; m_f = 0;

    //                  r i ru f  cut   sig  cnt v p f
    // reset
    vecs.push_back(mk(1,0,0,0,4'h0, 4'h0,0,0,0,0));
    vecs.push_back(mk(1,0,0,0,4'h0, 4'h0,0,0,0,0));
    // matching run A,5,F
    vecs.push_back(mk(0,1,0,0,4'h0, 4'h0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,4'hA, 4'hA,1,0,0,0));
    vecs.push_back(mk(0,0,1,0,4'h5, 4'h2,2,0,0,0));
    vecs.push_back(mk(0,0,1,0,4'hF, 4'hB,3,0,0,0));
    vecs.push_back(mk(0,0,0,1,4'h0, 4'hB,3,0,0,0));
    vecs.push_back(mk(0,0,0,0,4'h0, 4'hB,3,1,1,0));
    // strobes in DONE are ignored
    vecs.push_back(mk(0,0,1,0,4'h7, 4'hB,3,1,1,0));
    vecs.push_back(mk(0,0,0,1,4'h0, 4'hB,3,1,1,0));
    // signature mismatch A,4,F
    vecs.push_back(mk(0,1,0,0,4'h0, 4'h0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,4'hA, 4'hA,1,0,0,0));
    vecs.push_back(mk(0,0,1,0,4'h4, 4'h3,2,0,0,0));
    vecs.push_back(mk(0,0,1,0,4'hF, 4'h9,3,0,0,0));
    vecs.push_back(mk(0,0,0,1,4'h0, 4'h9,3,0,0,0));
    vecs.push_back(mk(0,0,0,0,4'h0, 4'h9,3,1,0,1));
    // count mismatch, then init clears verdict
    vecs.push_back(mk(0,1,0,0,4'h0, 4'h0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,4'hA, 4'hA,1,0,0,0));
    vecs.push_back(mk(0,0,1,0,4'h5, 4'h2,2,0,0,0));
    vecs.push_back(mk(0,0,0,1,4'h0, 4'h2,2,0,0,0));
    vecs.push_back(mk(0,0,0,0,4'h0, 4'h2,2,1,0,1));
    vecs.push_back(mk(0,1,0,0,4'h0, 4'h0,0,0,0,0));
    // running+finish together: no compaction
    vecs.push_back(mk(0,0,1,1,4'h5, 4'h0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,4'h0, 4'h0,0,1,0,1));
    // strobes in IDLE are ignored
    vecs.push_back(mk(1,0,0,0,4'h0, 4'h0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,4'hA, 4'h0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,4'h0, 4'h0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,4'h0, 4'h0,0,0,0,0));
    // reset mid-run aborts; later finish ignored
    vecs.push_back(mk(0,1,0,0,4'h0, 4'h0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,4'hA, 4'hA,1,0,0,0));
    vecs.push_back(mk(0,0,1,0,4'h5, 4'h2,2,0,0,0));
    vecs.push_back(mk(1,0,1,0,4'h3, 4'h0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,4'h0, 4'h0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,4'h0, 4'h0,0,0,0,0));
    // init and finish together: init wins, compaction restarts
    vecs.push_back(mk(0,1,0,0,4'h0, 4'h0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,4'hA, 4'hA,1,0,0,0));
    vecs.push_back(mk(0,1,0,1,4'h0, 4'h0,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,4'h5, 4'h5,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,4'h0, 4'h5,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,4'h0, 4'h5,1,1,0,1));

    foreach (vecs[k]) begin
      step(vecs[k].r, vecs[k].i, vecs[k].ru, vecs[k].f, vecs[k].c);
      chk($sformatf("vec%0d.sig", k),   int'(signature),   int'(vecs[k].e_sig));
      chk($sformatf("vec%0d.cnt", k),   int'(cycle_count), int'(vecs[k].e_cnt));
      chk($sformatf("vec%0d.valid", k), int'(sig_valid),   int'(vecs[k].e_v));
      chk($sformatf("vec%0d.pass", k),  int'(pass),        int'(vecs[k].e_p));
      chk($sformatf("vec%0d.fail", k),  int'(fail),        int'(vecs[k].e_f));
    end

    // cycle counter saturates at 255 while the signature keeps compacting
    step(0, 1, 0, 0, 4'h0);
    for (int k = 0; k < 300; k++) step(0, 0, 1, 0, 4'($urandom_range(0, 15)));
    chk("sat.cnt", int'(cycle_count), 255);
    chk_model("sat");
    step(0, 0, 0, 1, 4'h0);
    step(0, 0, 0, 0, 4'h0);
    chk("sat.fail", int'(fail), 1);
    chk_model("sat_verdict");

    // random strobes against the model
    for (int k = 0; k < 600; k++) begin
      logic r, i, ru, f;
      r  = ($urandom_range(0, 99) < 2);
      i  = ($urandom_range(0, 99) < 6);
      ru = ($urandom_range(0, 99) < 70);
      f  = ($urandom_range(0, 99) < 10);
      step(r, i, ru, f, 4'($urandom_range(0, 15)));
      chk_model($sformatf("rnd%0d", k));
      chk($sformatf("rnd%0d.excl", k), int'(pass & fail), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
